btn_bank: RTL and testbench
===========================

# btn_bank

Parametrised N-channel push-button conditioner for the pet controller front panel (salud, hambre, reset, test and future keys). Each channel synchronises an asynchronous button pin, debounces it, and turns it into clean one-cycle events: press, release, short click, long press and optional auto-repeat. It sits between the board pins and the game FSM and generalises the fixed four-button front end to any width and polarity, adding hold-time classification.

## Interface
- N_BTN, 4, number of channels
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
- DEBOUNCE_CYC, 4, consecutive stable cycles required to accept a level change (≥1)
- LONG_CYC, 20, hold cycles after press_pulse until long_pulse (≥1)
- REPEAT_CYC, 5, cycles between repeat_pulse events after long_pulse (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_in  in  N_BTN  raw asynchronous button pins
- repeat_en  in  N_BTN  per-channel auto-repeat enable, sampled every cycle
- level  out  N_BTN  debounced state, 1 = pressed
- press_pulse  out  N_BTN  one cycle on accepted press
- release_pulse  out  N_BTN  one cycle on accepted release
- click_pulse  out  N_BTN  one cycle on release when long_pulse was not issued for that press
- long_pulse  out  N_BTN  one cycle when hold reaches LONG_CYC
- repeat_pulse  out  N_BTN  one cycle every REPEAT_CYC while held past long, if repeat_en

## Operation
- Per channel: 2-FF synchroniser, polarity normalisation (pressed = 1), debouncer, hold FSM. Channels fully independent.
- Debouncer: counter increments while normalised sync level ≠ level; clears on any cycle where they match (bounce restarts count). When count reaches DEBOUNCE_CYC, level toggles and counter clears.
- Hold FSM states: IDLE, HELD, LONG.
  - IDLE → HELD on level rising; press_pulse same cycle; hold counter cleared.
  - HELD: hold counter +1 per cycle; at LONG_CYC → LONG, long_pulse, repeat counter cleared.
  - LONG: repeat counter +1; at REPEAT_CYC emit repeat_pulse if repeat_en=1, counter clears and continues regardless of repeat_en.
  - HELD or LONG → IDLE on level falling; release_pulse; click_pulse additionally only from HELD.
- Level falling in the same cycle hold counter would reach LONG_CYC: release wins, click_pulse issued, no long_pulse.
- Counter widths: $clog2(max+1) of the respective parameter; counters never wrap.
- repeat_en deasserted in LONG suppresses pulses immediately; reasserting resumes on next REPEAT_CYC boundary.

## Timing
- Reset: all outputs 0, synchroniser flops 0 (normalised released), counters 0, FSM IDLE.
- Press latency: pin change to press_pulse = 2 (sync) + DEBOUNCE_CYC cycles, glitch-free input.
- long_pulse exactly LONG_CYC cycles after press_pulse; first repeat_pulse REPEAT_CYC cycles after long_pulse, then every REPEAT_CYC.
- All pulses registered, exactly one cycle wide; press and release never coincide on one channel.
- Button held through reset: after rst falls, channel re-debounces and issues press_pulse at 2+DEBOUNCE_CYC cycles.
- Reset mid-hold: no release/click pulses generated by the reset itself.

## Structure
- btn_pkg: FSM state encoding (IDLE, HELD, LONG), counter-width helper function, parameter legality checks.
- Sub-module btn_chan: one channel (sync, debounce, FSM); btn_bank is a generate loop of N_BTN instances plus polarity handling.

## Test plan
- Defaults, channel 0 pin low for 10 cycles -> press_pulse[0] 6 cycles after edge, level[0]=1; release after 10 cycles -> release_pulse[0] and click_pulse[0] together, no long_pulse.
- Pin bouncing every 2 cycles for 20 cycles then stable low -> exactly one press_pulse, 6 cycles after final edge.
- Hold 60 cycles, repeat_en=1 -> long_pulse 20 cycles after press_pulse, repeat_pulse at +25, +30, +35 …; release -> release_pulse only, no click_pulse.
- Same hold with repeat_en toggled 0 mid-LONG -> repeats stop immediately, resume on next 5-cycle boundary when re-enabled.
- All 4 channels pressed at staggered offsets -> each channel's pulses independent and correctly timed; ACTIVE_LOW=0 build mirrors results with inverted pins.
- rst asserted while channel 2 in LONG with pin held -> all outputs 0 during rst; after release of rst press_pulse[2] at 6 cycles, no spurious release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Hold FSM encoding, counter sizing and parameter sanity.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } hold_st_t;

  function automatic int cnt_w(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic bit params_ok(
    input int n,
    input int d,
    input int l,
    input int r
  );
    return (n >= 1) && (d >= 1) && (l >= 1) && (r >= 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, debouncer and hold FSM.
// Input pin is already normalised so that 1 means pressed.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 20,
  parameter int REPEAT_CYC   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(LONG_CYC);
  localparam int RW = cnt_w(REPEAT_CYC);

  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] HD_MAX = HW'(LONG_CYC);
  localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CYC);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_nxt;
  logic          db_hit;
  logic          rise;
  logic          fall;
  hold_st_t      state;

  // next counter values and the debounced edge events
  always_comb begin
    db_nxt   = db_cnt + 1'b1;
    hold_nxt = hold_cnt + 1'b1;
    rpt_nxt  = rpt_cnt + 1'b1;
    db_hit   = (s2 != level) && (db_nxt == DB_MAX);
    rise     = db_hit && !level;
    fall     = db_hit && level;
  end

  // sync the pin, then accept a level change after a stable run
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == level) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_nxt;
      end
    end
  end

  // classify the hold time and emit registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state       <= HELD;
            hold_cnt    <= '0;
            press_pulse <= 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
          end else if (hold_nxt == HD_MAX) begin
            state      <= LONG;
            long_pulse <= 1'b1;
            rpt_cnt    <= '0;
          end else begin
            hold_cnt <= hold_nxt;
          end
        end
        LONG: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
          end else if (rpt_nxt == RP_MAX) begin
            rpt_cnt      <= '0;
            repeat_pulse <= repeat_en;
          end else begin
            rpt_cnt <= rpt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_bank.sv
// N-channel push-button conditioner for the front panel.
// Normalises pin polarity and fans out to independent channels.
module btn_bank
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 20,
  parameter int REPEAT_CYC   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] click_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  logic [N_BTN-1:0] pin;

  assign pin = ACTIVE_LOW ? ~btn_in : btn_in;

  if (!params_ok(N_BTN, DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) begin : g_bad
    $error("btn_bank: illegal parameters");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .pin          (pin[i]),
      .repeat_en    (repeat_en[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .click_pulse  (click_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_bank.sv
// Bench for btn_bank: table vectors, corner sequences, random traffic.
// Both polarity builds are checked against one timing model.
module tb_btn_bank;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pressed;
  logic [N-1:0] repeat_en;
  logic [N-1:0] btn_lo;
  logic [N-1:0] btn_hi;

  logic [N-1:0] lv_a, pr_a, rl_a, ck_a, lg_a, rp_a;
  logic [N-1:0] lv_b, pr_b, rl_b, ck_b, lg_b, rp_b;

  assign btn_lo = ~pressed;
  assign btn_hi = pressed;

  always #5 clk = ~clk;

  btn_bank #(
    .N_BTN(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(D),
    .LONG_CYC(L), .REPEAT_CYC(R)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_lo), .repeat_en(repeat_en),
    .level(lv_a), .press_pulse(pr_a), .release_pulse(rl_a),
    .click_pulse(ck_a), .long_pulse(lg_a), .repeat_pulse(rp_a)
  );

  btn_bank #(
    .N_BTN(N), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(D),
    .LONG_CYC(L), .REPEAT_CYC(R)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_hi), .repeat_en(repeat_en),
    .level(lv_b), .press_pulse(pr_b), .release_pulse(rl_b),
    .click_pulse(ck_b), .long_pulse(lg_b), .repeat_pulse(rp_b)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // model: pin delay line, acceptance run, press timestamp
  bit m_d1 [N];
  bit m_d2 [N];
  bit m_lvl[N];
  int m_run[N];
  int m_tp [N];
  logic [N-1:0] e_lv, e_pr, e_rl, e_ck, e_lg, e_rp;

  // observed pulse statistics
  int n_pr[N], n_rl[N], n_ck[N], n_lg[N], n_rp[N];
  int t_pr[N], t_lg[N];

  function automatic void cmpi(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, exp);
    end
  endfunction

  function automatic void cmpv(string nm, logic [6*N-1:0] act,
                               logic [6*N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endfunction

  task automatic model_step();
    bit d;
    int age;
    e_pr = '0; e_rl = '0; e_ck = '0; e_lg = '0; e_rp = '0;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0;
        m_run[c] = 0; m_tp[c] = -1;
      end else begin
        d = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = pressed[c];
        if (d != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_run[c] = 0;
            m_lvl[c] = !m_lvl[c];
            if (m_lvl[c]) begin
              e_pr[c] = 1'b1;
              m_tp[c] = t;
            end else begin
              e_rl[c] = 1'b1;
              e_ck[c] = ((t - m_tp[c]) <= L);
              m_tp[c] = -1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_lvl[c] && !e_pr[c]) begin
          age = t - m_tp[c];
          if (age == L) e_lg[c] = 1'b1;
          if (age > L && ((age - L) % R) == 0)
            e_rp[c] = repeat_en[c];
        end
      end
      e_lv[c] = m_lvl[c];
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      n_pr[c] = 0; n_rl[c] = 0; n_ck[c] = 0;
      n_lg[c] = 0; n_rp[c] = 0; t_pr[c] = -1; t_lg[c] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_step();
    @(negedge clk);
    cmpv("model_a", {lv_a, pr_a, rl_a, ck_a, lg_a, rp_a},
                    {e_lv, e_pr, e_rl, e_ck, e_lg, e_rp});
    cmpv("model_b", {lv_b, pr_b, rl_b, ck_b, lg_b, rp_b},
                    {e_lv, e_pr, e_rl, e_ck, e_lg, e_rp});
    for (int c = 0; c < N; c++) begin
      if (pr_a[c]) begin n_pr[c]++; t_pr[c] = t; end
      if (lg_a[c]) begin n_lg[c]++; t_lg[c] = t; end
      if (rl_a[c]) n_rl[c]++;
      if (ck_a[c]) n_ck[c]++;
      if (rp_a[c]) n_rp[c]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int hold;
    bit ren;
    int npress;
    int nlong;
    int nclick;
    int nrep;
  } vec_t;

  vec_t tbl[8];
  int   t0;
  int   dur[N];

  initial begin
    tbl[0] = '{10, 1'b1, 1, 0, 1, 0};
    tbl[1] = '{20, 1'b1, 1, 0, 1, 0};
    tbl[2] = '{21, 1'b1, 1, 1, 0, 0};
    tbl[3] = '{26, 1'b1, 1, 1, 0, 1};
    tbl[4] = '{60, 1'b1, 1, 1, 0, 7};
    tbl[5] = '{60, 1'b0, 1, 1, 0, 0};
    tbl[6] = '{4,  1'b0, 1, 0, 1, 0};
    tbl[7] = '{3,  1'b1, 0, 0, 0, 0};

    rst = 1'b1;
    pressed = '0;
    repeat_en = '0;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      tick();
      cmpv("reset_zero", {lv_a, pr_a, rl_a, ck_a, lg_a, rp_a}, '0);
    end
    rst = 1'b0;
    ticks(5);

    // table of single presses on channel 0
    foreach (tbl[k]) begin
      clear_counts();
      repeat_en[0] = tbl[k].ren;
      t0 = t;
      pressed[0] = 1'b1;
      ticks(tbl[k].hold);
      pressed[0] = 1'b0;
      ticks(40);
      cmpi("tbl_press", n_pr[0], tbl[k].npress);
      cmpi("tbl_release", n_rl[0], tbl[k].npress);
      cmpi("tbl_click", n_ck[0], tbl[k].nclick);
      cmpi("tbl_long", n_lg[0], tbl[k].nlong);
      cmpi("tbl_repeat", n_rp[0], tbl[k].nrep);
      if (tbl[k].npress > 0)
        cmpi("tbl_press_lat", t_pr[0] - t0, 2 + D);
      if (tbl[k].nlong > 0)
        cmpi("tbl_long_lat", t_lg[0] - t_pr[0], L);
    end

    // bouncing pin settles low: one press after the last edge
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      pressed[0] = ~i[0];
      ticks(2);
    end
    t0 = t;
    pressed[0] = 1'b1;
    ticks(30);
    cmpi("bounce_press", n_pr[0], 1);
    cmpi("bounce_lat", t_pr[0] - t0, 2 + D);
    pressed[0] = 1'b0;
    ticks(40);

    // repeat_en dropped mid-LONG, then restored
    clear_counts();
    for (int i = 0; i < 50; i++) begin
      pressed[0] = 1'b1;
      repeat_en[0] = !(i >= 32 && i < 42);
      tick();
    end
    pressed[0] = 1'b0;
    repeat_en[0] = 1'b1;
    ticks(40);
    cmpi("ren_gap_repeat", n_rp[0], 3);
    cmpi("ren_gap_long", n_lg[0], 1);
    cmpi("ren_gap_click", n_ck[0], 0);

    // reset while channel 2 is in LONG with the pin held
    clear_counts();
    pressed[2] = 1'b1;
    ticks(30);
    cmpi("pre_rst_long", n_lg[2], 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmpv("rst_hold_zero", {lv_a, pr_a, rl_a, ck_a, lg_a, rp_a}, '0);
    end
    rst = 1'b0;
    clear_counts();
    t0 = t;
    ticks(20);
    cmpi("rst_repress", n_pr[2], 1);
    cmpi("rst_repress_lat", t_pr[2] - t0, 2 + D);
    cmpi("rst_no_release", n_rl[2], 0);
    pressed[2] = 1'b0;
    ticks(40);

    // staggered presses on all channels
    clear_counts();
    repeat_en = '1;
    for (int i = 0; i < 80; i++) begin
      for (int c = 0; c < N; c++)
        pressed[c] = (i >= 3 * c) && (i < 3 * c + 15 + 12 * c);
      tick();
    end
    ticks(30);
    for (int c = 0; c < N; c++) cmpi("stagger_press", n_pr[c], 1);
    cmpi("stagger_click0", n_ck[0], 1);
    cmpi("stagger_long3", n_lg[3], 1);

    // random traffic against the model
    for (int c = 0; c < N; c++) dur[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (dur[c] == 0) begin
          pressed[c] = ~pressed[c];
          dur[c] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) :
                   int'($urandom_range(4, 70));
        end
        dur[c]--;
        if ($urandom_range(0, 29) == 0) repeat_en[c] = ~repeat_en[c];
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    pressed = '0;
    ticks(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
